// File: rtl/serial_manchester_tx_pkg.sv
// Shared types and default constants for the Manchester serial transmitter and its CDR bench.
// The PARITY state exists only when SERIAL_MANCHESTER_TX_PARITY_EN is defined.
package serial_manchester_pkg;

   localparam int DEF_DATA_W        = 8;
   localparam int DEF_HALF_BIT_CLKS = 4;
   localparam int LOCK_WINDOW_BITS  = 20;
   localparam int DEF_GAP_BITS      = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DELIM,
      ST_DATA,
`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_GAP
   } tx_state_t;

endpackage

// File: rtl/serial_manchester_tx_halfbit_timer.sv
// Half-bit timer: strobe marks the last clk cycle of each Manchester half-bit.
// clr restarts the count so the first half-bit after acceptance is full length.
module manchester_halfbit_timer #(
   parameter int HALF_BIT_CLKS = 4
) (
   input  logic clk,
   input  logic clr,
   output logic strobe
);

   localparam int CW = $clog2(HALF_BIT_CLKS + 1);
   localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CLKS - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (clr || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign strobe = (cnt == LAST);

endmodule

// File: rtl/serial_manchester_tx.sv
// Manchester (IEEE 802.3) frame transmitter: preamble of 1s, one 0 delimiter, LSB-first payload, idle gap.
// Define SERIAL_MANCHESTER_TX_PARITY_EN to append an even-parity bit after the payload MSB.
module serial_manchester_tx
   import serial_manchester_pkg::*;
#(
   parameter int DATA_W        = DEF_DATA_W,
   parameter int HALF_BIT_CLKS = DEF_HALF_BIT_CLKS,
   parameter int PREAMBLE_BITS = LOCK_WINDOW_BITS,
   parameter int GAP_BITS      = DEF_GAP_BITS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              data_out,
   output logic              busy,
   output logic              lock_sent
);

   localparam int MAX_A    = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
   localparam int MAX_BITS = (MAX_A > GAP_BITS) ? MAX_A : GAP_BITS;
   localparam int CNT_W    = $clog2(MAX_BITS + 1);

   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_BITS > 0) ? CNT_W'(GAP_BITS - 1) : '0;
   localparam tx_state_t        END_STATE = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;

   tx_state_t         state, state_n;
   logic              half_q, half_n;
   logic [CNT_W-1:0]  bit_q, bit_n;
   logic [DATA_W-1:0] shreg_q, shreg_n;
`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
   logic              parity_q, parity_n;
`endif
   logic              half_strobe, timer_clr, accept;
   logic              bit_val, on_line, line_n;
   logic              ready_n, busy_n, lock_n;

   assign accept = tx_valid & tx_ready;
   // Timer is held cleared throughout IDLE, so it starts fresh on the accepting edge.
   assign timer_clr = ~rst_n | (state == ST_IDLE);

   manchester_halfbit_timer #(
      .HALF_BIT_CLKS(HALF_BIT_CLKS)
   ) u_timer (
      .clk   (clk),
      .clr   (timer_clr),
      .strobe(half_strobe)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         half_q    <= 1'b0;
         bit_q     <= '0;
         shreg_q   <= '0;
`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
         data_out  <= 1'b0;
         tx_ready  <= 1'b0;
         busy      <= 1'b0;
         lock_sent <= 1'b0;
      end else begin
         state     <= state_n;
         half_q    <= half_n;
         bit_q     <= bit_n;
         shreg_q   <= shreg_n;
`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
         parity_q  <= parity_n;
`endif
         data_out  <= line_n;
         tx_ready  <= ready_n;
         busy      <= busy_n;
         lock_sent <= lock_n;
      end
   end

   always_comb begin
      state_n  = state;
      half_n   = half_q;
      bit_n    = bit_q;
      shreg_n  = shreg_q;
`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
      parity_n = parity_q;
`endif
      if (state == ST_IDLE) begin
         if (accept) begin
            state_n  = ST_PREAMBLE;
            half_n   = 1'b0;
            bit_n    = '0;
            shreg_n  = tx_data;
`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
            parity_n = ^tx_data;
`endif
         end
      end else if (half_strobe) begin
         half_n = ~half_q;
         if (half_q) begin
            bit_n = bit_q + CNT_W'(1);
            case (state)
               ST_PREAMBLE: if (bit_q == PRE_LAST) begin
                  state_n = ST_DELIM;
                  bit_n   = '0;
               end
               ST_DELIM: begin
                  state_n = ST_DATA;
                  bit_n   = '0;
               end
               ST_DATA: begin
                  shreg_n = shreg_q >> 1;
                  if (bit_q == DATA_LAST) begin
`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
                     state_n = ST_PARITY;
`else
                     state_n = END_STATE;
`endif
                     bit_n   = '0;
                  end
               end
`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
               ST_PARITY: begin
                  state_n = END_STATE;
                  bit_n   = '0;
               end
`endif
               ST_GAP: if (bit_q == GAP_LAST) begin
                  state_n = ST_IDLE;
                  bit_n   = '0;
               end
               default: state_n = ST_IDLE;
            endcase
         end
      end

      // Line level is built from next-state values so the registered output carries no extra latency.
      bit_val = 1'b0;
      on_line = 1'b0;
      case (state_n)
         ST_PREAMBLE: begin bit_val = 1'b1;       on_line = 1'b1; end
         ST_DELIM:    begin bit_val = 1'b0;       on_line = 1'b1; end
         ST_DATA:     begin bit_val = shreg_n[0]; on_line = 1'b1; end
`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
         ST_PARITY:   begin bit_val = parity_n;   on_line = 1'b1; end
`endif
         default:     begin bit_val = 1'b0;       on_line = 1'b0; end
      endcase
      line_n  = on_line & (half_n ? bit_val : ~bit_val);

      ready_n = (state_n == ST_IDLE);
      busy_n  = (state_n != ST_IDLE);
      lock_n  = (state == ST_PREAMBLE) && (state_n == ST_DELIM);
   end

endmodule

// File: tb/tb_serial_manchester_tx.sv
// Directed bench for serial_manchester_tx: default instance plus a HALF_BIT_CLKS=1, GAP_BITS=0 instance.
// Line captures are decoded per bit and compared against hand-computed frames.
module tb_serial_manchester_tx;
   import serial_manchester_pkg::*;

`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
   localparam int NB      = 30;
   localparam int FRAME_D = 240;
   localparam int FRAME_F = 60;
`else
   localparam int NB      = 29;
   localparam int FRAME_D = 232;
   localparam int FRAME_F = 58;
`endif
   localparam int GAP_D  = 16;
   localparam int LOCK_D = 160;
   localparam int LOCK_F = 40;
   localparam int PRE_B  = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data, tx_data_f;
   logic       tx_valid, tx_valid_f;
   logic       tx_ready, data_out, busy, lock_sent;
   logic       tx_ready_f, data_out_f, busy_f, lock_sent_f;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic ln [2][600];
   logic bz [2][600];
   logic rd [2][600];
   logic lk [2][600];
   logic [NB-1:0] dec_bits;

   always #5 clk = ~clk;

   serial_manchester_tx dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .data_out (data_out),
      .busy     (busy),
      .lock_sent(lock_sent)
   );

   serial_manchester_tx #(
      .HALF_BIT_CLKS(1),
      .GAP_BITS     (0)
   ) dut_f (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data_f),
      .tx_valid (tx_valid_f),
      .tx_ready (tx_ready_f),
      .data_out (data_out_f),
      .busy     (busy_f),
      .lock_sent(lock_sent_f)
   );

   task automatic check_vec(input string tag, input int got, input int exp);
      vec_cnt++;
      if (got != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         ln[0][i] = data_out;   bz[0][i] = busy;   rd[0][i] = tx_ready;   lk[0][i] = lock_sent;
         ln[1][i] = data_out_f; bz[1][i] = busy_f; rd[1][i] = tx_ready_f; lk[1][i] = lock_sent_f;
         if (i < n - 1) tick();
      end
   endtask

   task automatic check_frame(input int u, input int base, input int hb, input int frame_exp,
                              input int gap_exp, input int lock_exp, input logic [7:0] exp_d,
                              input string tag);
      int trans, glitch, ones, gz, blen, lcnt, lidx, rises, cidx, p;
      logic f, s, prev;
      logic [7:0] got_d;
      trans = 0; glitch = 0; ones = 0; gz = 0; blen = 0; lcnt = 0; lidx = -1; rises = 0; cidx = -1;
      for (int b = 0; b < NB; b++) begin
         p = base + 2 * hb * b;
         f = ln[u][p];
         s = ln[u][p + hb];
         for (int k = 0; k < hb; k++) begin
            if (ln[u][p + k] != f) glitch++;
            if (ln[u][p + hb + k] != s) glitch++;
         end
         if (f != s) trans++;
         dec_bits[b] = s;
      end
      for (int b = 0; b < PRE_B; b++) if (dec_bits[b]) ones++;
      for (int i = 0; i < 8; i++) got_d[i] = dec_bits[PRE_B + 1 + i];
      check_vec($sformatf("%s_ready_drop", tag), rd[u][base], 0);
      check_vec($sformatf("%s_midbit", tag), trans, NB);
      check_vec($sformatf("%s_halfstable", tag), glitch, 0);
      check_vec($sformatf("%s_preamble", tag), ones, PRE_B);
      check_vec($sformatf("%s_delim", tag), dec_bits[PRE_B], 0);
      check_vec($sformatf("%s_data", tag), got_d, exp_d);
      for (int i = 0; i < gap_exp; i++) if (ln[u][base + frame_exp + i]) gz++;
      check_vec($sformatf("%s_gap_zero", tag), gz, 0);
      for (int i = 0; i < frame_exp + gap_exp; i++) if (bz[u][base + i]) blen++;
      check_vec($sformatf("%s_busy_len", tag), blen, frame_exp + gap_exp);
      check_vec($sformatf("%s_end_busy", tag), bz[u][base + frame_exp + gap_exp], 0);
      check_vec($sformatf("%s_end_ready", tag), rd[u][base + frame_exp + gap_exp], 1);
      for (int i = 0; i < frame_exp + gap_exp; i++) begin
         if (lk[u][base + i]) begin
            lcnt++;
            lidx = i;
         end
      end
      check_vec($sformatf("%s_lock_cnt", tag), lcnt, 1);
      check_vec($sformatf("%s_lock_at", tag), lidx, lock_exp);
      // CDR model: declares lock on the LOCK_WINDOW_BITS-th rising mid-bit edge.
      prev = 1'b0;
      for (int i = 0; i < frame_exp; i++) begin
         if (!prev && ln[u][base + i]) begin
            rises++;
            if (rises == LOCK_WINDOW_BITS && cidx < 0) cidx = i;
         end
         prev = ln[u][base + i];
      end
      check_vec($sformatf("%s_cdr_lock", tag), (cidx >= 0 && cidx <= lidx) ? 1 : 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      int chg, bsum;
      logic prev;
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_valid_f = 1'b0; tx_data_f = '0;
      repeat (3) tick();
      check_vec("rst_ready", tx_ready, 0);
      check_vec("rst_busy", busy, 0);
      check_vec("rst_line", data_out, 0);
      check_vec("rst_lock", lock_sent, 0);
      rst_n = 1'b1;
      tick();
      check_vec("rel_ready", tx_ready, 1);
      check_vec("rel_ready_f", tx_ready_f, 1);

      // A5, single-cycle valid, input changed after acceptance
      tx_data = 8'hA5; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0; tx_data = 8'h3C;
      capture(FRAME_D + GAP_D + 1);
      check_frame(0, 0, 4, FRAME_D, GAP_D, LOCK_D, 8'hA5, "a5");
`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
      check_vec("a5_parity", dec_bits[NB-1], 0);
`endif

      tx_data = 8'h07; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      capture(FRAME_D + GAP_D + 1);
      check_frame(0, 0, 4, FRAME_D, GAP_D, LOCK_D, 8'h07, "x07");
`ifdef SERIAL_MANCHESTER_TX_PARITY_EN
      check_vec("x07_parity", dec_bits[NB-1], 1);
`endif

      // back-to-back with valid held
      tx_data = 8'h00; tx_valid = 1'b1;
      tick();
      tx_data = 8'hFF;
      capture(2 * (FRAME_D + GAP_D + 1));
      tx_valid = 1'b0;
      check_frame(0, 0, 4, FRAME_D, GAP_D, LOCK_D, 8'h00, "b2b00");
      check_vec("b2b_reaccept_busy", bz[0][FRAME_D + GAP_D + 1], 1);
      check_vec("b2b_reaccept_ready", rd[0][FRAME_D + GAP_D + 1], 0);
      check_frame(0, FRAME_D + GAP_D + 1, 4, FRAME_D, GAP_D, LOCK_D, 8'hFF, "b2bFF");
      tick();

      // reset at cycle 100 of a frame
      tx_data = 8'hA5; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      repeat (100) tick();
      check_vec("mid_pre_rst_line", data_out, 1);
      rst_n = 1'b0;
      tick();
      check_vec("mid_rst_line", data_out, 0);
      check_vec("mid_rst_busy", busy, 0);
      check_vec("mid_rst_ready", tx_ready, 0);
      rst_n = 1'b1;
      tick();
      check_vec("mid_rel_ready", tx_ready, 1);
      check_vec("mid_rel_busy", busy, 0);
      chg = 0; bsum = 0; prev = data_out;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (data_out != prev) chg++;
         if (busy) bsum++;
         prev = data_out;
      end
      check_vec("mid_no_activity", chg + (prev ? 1 : 0), 0);
      check_vec("mid_no_busy", bsum, 0);

      // HALF_BIT_CLKS=1, GAP_BITS=0 instance
      tx_data_f = 8'hC3; tx_valid_f = 1'b1;
      tick();
      tx_valid_f = 1'b0;
      capture(FRAME_F + 1);
      check_frame(1, 0, 1, FRAME_F, 0, LOCK_F, 8'hC3, "fast");
      check_vec("fast_last_busy", bz[1][FRAME_F - 1], 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/serial_manchester_tx.md
SERIAL_MANCHESTER_TX -- requirements
Module: serial_manchester_tx

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning payload bits per frame.
REQ-002 The module SHALL have parameter HALF_BIT_CLKS, default 4 (min 1), meaning clk cycles per Manchester half-bit.
REQ-003 The module SHALL have parameter PREAMBLE_BITS, default 20 (min 1), meaning lock bits sent before the delimiter.
REQ-004 The module SHALL have parameter GAP_BITS, default 2 (min 0), meaning idle bit times after each frame.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge clk.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The module SHALL have port tx_data, input, DATA_W bits: payload to send.
REQ-008 The module SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-009 The module SHALL have port tx_ready, output, 1 bit: the block accepts a payload this cycle.
REQ-010 The module SHALL have port data_out, output, 1 bit: registered serial line to the CDR receiver.
REQ-011 The module SHALL have port busy, output, 1 bit: a frame or gap is in progress.
REQ-012 The module SHALL have port lock_sent, output, 1 bit: one-cycle pulse when the last preamble bit completes.

Function
REQ-013 The module SHALL implement states IDLE, PREAMBLE, DELIM, DATA, PARITY and GAP.
REQ-014 Encoding SHALL follow IEEE 802.3: bit 0 = first half high, second half low; bit 1 = first half low, second half high; each half lasts HALF_BIT_CLKS cycles.
REQ-015 In IDLE, tx_ready SHALL be 1, busy 0 and data_out 0; in all other states tx_ready SHALL be 0.
REQ-016 On tx_valid && tx_ready, the block SHALL latch tx_data and enter PREAMBLE; tx_data changes after acceptance SHALL not affect the frame.
REQ-017 data_out SHALL present the first half-bit starting the cycle after acceptance.
REQ-018 PREAMBLE SHALL send PREAMBLE_BITS encoded 1 bits, then assert lock_sent for exactly one cycle, coincident with the first DELIM cycle.
REQ-019 DELIM SHALL send one encoded 0 bit; the resulting phase reversal marks the start of payload.
REQ-020 DATA SHALL send DATA_W bits LSB first.
REQ-021 GAP SHALL hold data_out 0 for GAP_BITS*2*HALF_BIT_CLKS cycles, then enter IDLE; when GAP_BITS = 0, the block SHALL go directly to IDLE.
REQ-022 busy SHALL be 1 from the cycle after acceptance through the last GAP cycle inclusive.
REQ-023 Frame length without gap SHALL be (PREAMBLE_BITS+1+DATA_W[+1 parity])*2*HALF_BIT_CLKS cycles.
REQ-024 The bit-time and bit-index counters SHALL be sized with $clog2 of their maximum values plus 1, and SHALL not wrap during a frame.
REQ-025 A tx_valid held through a frame SHALL be accepted on the first IDLE cycle after the gap; back-to-back frames SHALL therefore be separated by exactly one IDLE cycle plus the gap.

Reset
REQ-026 While rst_n = 0 at a clk edge, the block SHALL set state IDLE, data_out 0, tx_ready 0, busy 0, lock_sent 0 and clear all counters.
REQ-027 tx_ready SHALL rise on the first clk edge with rst_n = 1.
REQ-028 Reset mid-frame SHALL abort the frame with no further line activity; no partial frame SHALL resume.

Configuration
REQ-029 With macro SERIAL_MANCHESTER_TX_PARITY_EN defined, the block SHALL send one PARITY bit (even parity over DATA_W bits) after the MSB, before GAP.
REQ-030 Without SERIAL_MANCHESTER_TX_PARITY_EN, the PARITY state SHALL be absent, and DATA SHALL go directly to GAP.

Structure
REQ-031 Package serial_manchester_pkg SHALL hold the state enum typedef and constants for the default parameters (LOCK_WINDOW_BITS = 20), shared with the CDR bench.
REQ-032 Sub-module manchester_halfbit_timer SHALL generate a half-bit strobe from HALF_BIT_CLKS, with a sync clear from the FSM on acceptance and on reset.

Verification
REQ-033 The bench SHALL check: reset, then tx_data=8'hA5 with valid for 1 cycle -> ready drops the next cycle, 20 preamble 1s, delimiter 0, line bits 1,0,1,0,0,1,0,1 (LSB first), frame = 232 cycles at default parameters, busy through +16 gap cycles.
REQ-034 The bench SHALL check lock_sent: it pulses exactly once per frame, 160 cycles after acceptance at default parameters; the CDR model lock asserts at or before that pulse.
REQ-035 The bench SHALL check back-to-back 8'h00 and 8'hFF with valid held high -> second acceptance exactly 1+16 cycles after the first frame ends; every bit has a mid-bit transition.
REQ-036 The bench SHALL check rst_n=0 for 1 cycle at cycle 100 of a frame -> data_out 0 at the next edge, busy 0, tx_ready 1 one cycle after release, no further transitions.
REQ-037 The bench SHALL check, with PARITY_EN, 8'h07 -> parity bit 1 appended and frame = 240 cycles; without PARITY_EN, 232 cycles.
REQ-038 The bench SHALL check HALF_BIT_CLKS=1, GAP_BITS=0 -> 2-cycle bit times and a direct return to IDLE with no gap.
